codec_init_sequencer: RTL
=========================

Name: codec_init_sequencer

Overview:
- Upstream command source for the codec control I2C engine.
- After reset, or on a re-run request, walks a register table in an external synchronous ROM. Each 16-bit entry is {reg_addr[6:0], reg_data[8:0]}; the codec uses a 7-bit register address and 9-bit data.
- Each entry becomes one I2C write: START, device byte, two data bytes, STOP. Ops are handed to the engine over a valid/ready handshake.
- Checks the ACK of every byte, retries a failed transaction, and reports busy/done/error to the deck top level.

Parameters:
- C_DEV_ADDR, 7'h1A: 7-bit codec I2C address. The device byte sent is {C_DEV_ADDR, 1'b0}.
- C_NUM_REGS, 11: number of table entries. Range 1..255.
- C_PWR_DELAY, 16'd1000: idle clocks between reset release and the first START, for codec power-up.
- C_MAX_RETRIES, 3: retries allowed per entry after the first failed attempt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  single-cycle pulse. Restarts the sequence from entry 0 when in DONE or ERROR; ignored otherwise.
- tbl_addr  out  8  ROM read address.
- tbl_data  in  16  ROM read data, valid one clk after tbl_addr is presented.
- op  out  2  engine op: 2'b00 START, 2'b01 WRITE byte, 2'b10 STOP, 2'b11 reserved (never issued).
- tx_byte  out  8  byte for a WRITE op; 8'h00 otherwise.
- op_valid  out  1  op/tx_byte are valid.
- op_ready  in  1  engine accepts the op.
- op_done  in  1  one-cycle pulse when the engine finishes an accepted op.
- ack_ok  in  1  sampled with op_done on WRITE ops; 1 = slave ACKed.
- busy  out  1  sequence in progress.
- done  out  1  all entries written successfully; level signal.
- error  out  1  retries exhausted; level signal.
- err_index  out  8  table index of the failing entry.

Behaviour:
- Reset values (async assert, sync-safe release): all outputs 0 (op=00, tx_byte=00, tbl_addr=00); state = PWR_WAIT; retry count 0; delay counter 0.
- Handshake:
  - op_valid, op and tx_byte are registered and held stable until the cycle op_valid && op_ready. op_valid drops the next cycle.
  - The sequencer then waits for op_done. Only one op is outstanding at a time.
  - op_done is ignored in any state that is not waiting for it.
- States:
  - PWR_WAIT: count C_PWR_DELAY clks with busy=1, then go to FETCH with index=0.
  - FETCH: drive tbl_addr=index, then wait one clk (FETCH_WAIT). Capture tbl_data into entry_r. Go to START.
  - START: issue op=00. On op_done go to DEV.
  - DEV: issue WRITE {C_DEV_ADDR,0}.
  - REGA: issue WRITE entry_r[15:8]; this equals {reg_addr, data[8]}.
  - REGD: issue WRITE entry_r[7:0].
  - ACK checking in DEV, REGA and REGD: after op_done, if ack_ok=1 go to the next state. If ack_ok=0, set nack_flag and skip straight to STOP; remaining bytes are not sent.
  - STOP: issue op=10. STOP is always issued, including after a NACK. On op_done go to CHECK.
  - CHECK, nack_flag=0: clear retry count.
    - If index==C_NUM_REGS-1, go to DONE.
    - Otherwise index+1, go to FETCH.
  - CHECK, nack_flag=1: clear nack_flag.
    - If retry count < C_MAX_RETRIES, increment it and go to FETCH with the same index. The entry is re-fetched.
    - Otherwise go to ERROR, with err_index=index.
  - DONE: busy=0, done=1.
  - ERROR: busy=0, error=1.
  - From DONE or ERROR, run=1 clears done, error, err_index, index and retry count, and goes to FETCH. The power delay is not repeated.
- busy is 1 in every state except DONE and ERROR. done and error are mutually exclusive.
- Counters:
  - The delay counter is 16 bit. C_PWR_DELAY=0 means FETCH on the first clk after reset release.
  - The index is 8 bit and never wraps, because it is bounded by C_NUM_REGS-1.
  - The retry counter is 3 bit (wide enough for C_MAX_RETRIES up to 7).
- rst_n assertion mid-transaction: immediate return to reset values. The engine is reset by the same rst_n, so no STOP is owed.
- run while busy: ignored, no queuing.
- An op_ready that has already been high before op_valid rises causes no problem; acceptance requires both signals high in the same cycle.

Test Plan:
- Reset release, C_PWR_DELAY=4, C_NUM_REGS=2, ROM={16'h1E00, 16'h0C12}, engine model always ACKs. Required response:
  - First op_valid appears 4+ clks after reset release.
  - Op stream: START, W34, W1E, W00, STOP, START, W34, W0C, W12, STOP.
  - done=1, busy=0 at the end.
- Engine holds op_ready=0 for 10 clks on every op. Required: op/tx_byte stay stable throughout and exactly one op is accepted per handshake.
- NACK on the REGA byte of entry 1 once. Required: STOP follows immediately with no REGD. Entry 1 is re-fetched and re-sent in full; done=1; error stays 0.
- Device byte always NACKed with C_MAX_RETRIES=3. Required: exactly 4 START/W34/STOP triplets, then error=1, err_index=0, busy=0, no further ops.
- From ERROR, pulse run with the engine now ACKing. Required: sequence restarts at tbl_addr=0 with no power delay; error clears the cycle after run; done=1 at the end.
- rst_n pulsed low during REGD of entry 0. Required: outputs go to reset values asynchronously; after release, PWR_WAIT runs again and the sequence restarts at entry 0.

Source files
------------

// File: rtl/codec_init_sequencer.sv
// Codec register-table init sequencer.
// Walks an external synchronous ROM of {reg_addr[6:0], reg_data[8:0]} entries
// and turns each into one I2C write (START, device byte, two data bytes, STOP)
// for the I2C engine, with per-byte ACK checking and bounded per-entry retries.
module codec_init_sequencer #(
  parameter logic [6:0]  C_DEV_ADDR    = 7'h1A,
  parameter int unsigned C_NUM_REGS    = 11,
  parameter logic [15:0] C_PWR_DELAY   = 16'd1000,
  parameter int unsigned C_MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic [1:0]  op,
  output logic [7:0]  tx_byte,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        op_done,
  input  logic        ack_ok,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index
);

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_FETCH_WAIT,
    S_START,
    S_DEV,
    S_REGA,
    S_REGD,
    S_STOP,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Engine op codes are fixed by the engine interface.
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;

  localparam logic [7:0] LAST_IDX  = 8'(C_NUM_REGS - 1);
  localparam logic [2:0] MAX_RETRY = 3'(C_MAX_RETRIES);

  state_t      state_r, state_nx;
  logic [15:0] dly_r;
  logic [7:0]  index_r;
  logic [2:0]  retry_r;
  logic [15:0] entry_r;
  logic        nack_r;
  logic        wait_r;      // op accepted, waiting for op_done
  logic        op_valid_r;
  logic [1:0]  op_r;
  logic [7:0]  tx_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [7:0]  err_index_r;

  logic        xfer_done;
  logic        op_state;
  logic [1:0]  op_sel;
  logic [7:0]  byte_sel;
  logic        issue;

  assign xfer_done = wait_r && op_done;
  assign issue     = op_state && !op_valid_r && !wait_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_PWR_WAIT;
    else        state_r <= state_nx;
  end

  // Next-state decode: op states advance only when their accepted op completes.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_PWR_WAIT:   if (dly_r == C_PWR_DELAY) state_nx = S_FETCH;
      S_FETCH:      state_nx = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nx = S_START;
      S_START:      if (xfer_done) state_nx = S_DEV;
      S_DEV:        if (xfer_done) state_nx = ack_ok ? S_REGA : S_STOP;
      S_REGA:       if (xfer_done) state_nx = ack_ok ? S_REGD : S_STOP;
      S_REGD:       if (xfer_done) state_nx = S_STOP;
      S_STOP:       if (xfer_done) state_nx = S_CHECK;
      S_CHECK: begin
        if (!nack_r) state_nx = (index_r == LAST_IDX) ? S_DONE : S_FETCH;
        else         state_nx = (retry_r < MAX_RETRY) ? S_FETCH : S_ERROR;
      end
      S_DONE, S_ERROR: if (run) state_nx = S_FETCH;
      default:      state_nx = S_PWR_WAIT;
    endcase
  end

  // Output decode: which op and byte the current state presents to the engine.
  always_comb begin
    op_state = 1'b0;
    op_sel   = OP_START;
    byte_sel = '0;
    case (state_r)
      S_START: op_state = 1'b1;
      S_DEV: begin
        op_state = 1'b1;
        op_sel   = OP_WRITE;
        byte_sel = {C_DEV_ADDR, 1'b0};
      end
      S_REGA: begin
        op_state = 1'b1;
        op_sel   = OP_WRITE;
        byte_sel = entry_r[15:8];
      end
      S_REGD: begin
        op_state = 1'b1;
        op_sel   = OP_WRITE;
        byte_sel = entry_r[7:0];
      end
      S_STOP: begin
        op_state = 1'b1;
        op_sel   = OP_STOP;
      end
      default: ;
    endcase
  end

  // Datapath: handshake registers, counters, entry capture and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_r       <= '0;
      index_r     <= '0;
      retry_r     <= '0;
      entry_r     <= '0;
      nack_r      <= 1'b0;
      wait_r      <= 1'b0;
      op_valid_r  <= 1'b0;
      op_r        <= OP_START;
      tx_r        <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_index_r <= '0;
    end else begin
      // Status flags follow the state being entered so they line up with it.
      busy_r  <= (state_nx != S_DONE) && (state_nx != S_ERROR);
      done_r  <= (state_nx == S_DONE);
      error_r <= (state_nx == S_ERROR);

      if (issue) begin
        op_valid_r <= 1'b1;
        op_r       <= op_sel;
        tx_r       <= byte_sel;
      end else if (op_valid_r && op_ready) begin
        op_valid_r <= 1'b0;
        wait_r     <= 1'b1;
      end else if (xfer_done) begin
        wait_r     <= 1'b0;
      end

      if (state_r == S_PWR_WAIT && dly_r != C_PWR_DELAY)
        dly_r <= dly_r + 16'd1;

      if (state_r == S_FETCH_WAIT)
        entry_r <= tbl_data;

      if (xfer_done && !ack_ok &&
          (state_r == S_DEV || state_r == S_REGA || state_r == S_REGD))
        nack_r <= 1'b1;

      if (state_r == S_CHECK) begin
        if (!nack_r) begin
          retry_r <= '0;
          if (index_r != LAST_IDX) index_r <= index_r + 8'd1;
        end else begin
          nack_r <= 1'b0;
          if (retry_r < MAX_RETRY) retry_r <= retry_r + 3'd1;
          else                     err_index_r <= index_r;
        end
      end

      if ((state_r == S_DONE || state_r == S_ERROR) && run) begin
        index_r     <= '0;
        retry_r     <= '0;
        err_index_r <= '0;
      end
    end
  end

  assign tbl_addr  = index_r;
  assign op        = op_r;
  assign tx_byte   = tx_r;
  assign op_valid  = op_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_index = err_index_r;

endmodule
